// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction
// in flight at a time, data-first with a bounded streak so fetch cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_ready_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [1:0]        d_size_i,
  output logic              d_ready_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [1:0]        mem_size_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [1:0]          r_mem_size;
  logic                r_f_rvalid;
  logic [DATA_W-1:0]   r_f_rdata;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_err;
  logic                w_grant_d;
  logic                w_grant_f;
  logic                w_accept;
  logic                w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Data wins unless fetch is waiting and data has used up its streak allowance.
  always_comb begin
    w_grant_d    = d_req_i && !(f_req_i && (r_streak == STREAK_W'(MAX_DATA_STREAK)));
    w_grant_f    = f_req_i && !w_grant_d;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d || w_grant_f) begin
          w_accept     = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_gnt_i) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_streak    <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= 2'd0;
      r_f_rvalid  <= 1'b0;
      r_f_rdata   <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;

      if (w_accept) begin
        r_owner   <= w_grant_d;
        r_mem_req <= 1'b1;
        if (w_grant_d) begin
          r_mem_we    <= d_we_i;
          r_mem_addr  <= d_addr_i;
          r_mem_wdata <= d_wdata_i;
          r_mem_size  <= d_size_i;
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_addr  <= f_addr_i;
          r_mem_wdata <= '0;
          r_mem_size  <= 2'd2;
        end
      end

      if (r_state == S_ISSUE && mem_gnt_i) begin
        r_mem_req <= 1'b0;
        r_cnt     <= '0;
      end

      // A timeout completes the transaction like a response, but with zero data.
      if (r_state == S_WAIT) begin
        if (mem_rvalid_i || w_timeout) begin
          if (r_owner) begin
            r_d_rvalid <= 1'b1;
            r_d_rdata  <= mem_rvalid_i ? mem_rdata_i : '0;
          end else begin
            r_f_rvalid <= 1'b1;
            r_f_rdata  <= mem_rvalid_i ? mem_rdata_i : '0;
          end
          if (!mem_rvalid_i) begin
            r_err <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      if (!f_req_i) begin
        r_streak <= '0;
      end else if (w_accept && w_grant_f) begin
        r_streak <= '0;
      end else if (w_accept && w_grant_d && (r_streak != STREAK_W'(MAX_DATA_STREAK))) begin
        r_streak <= r_streak + STREAK_W'(1);
      end
    end
  end

  assign f_ready_o   = (r_state == S_IDLE) && w_grant_f;
  assign d_ready_o   = (r_state == S_IDLE) && w_grant_d;
  assign busy_o      = (r_state != S_IDLE);
  assign err_o       = r_err;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_size_o  = r_mem_size;
  assign f_rvalid_o  = r_f_rvalid;
  assign f_rdata_o   = r_f_rdata;
  assign d_rvalid_o  = r_d_rvalid;
  assign d_rdata_o   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for single and back-to-back
// transactions, plus sequences for store stalls, streak fairness, timeout and reset.
module tb_mem_port_arbiter;

  typedef struct {
    logic        rst;
    logic        fReq;
    logic [31:0] fAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [1:0]  dSize;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        fReady;
    logic        dReady;
    logic        memReq;
    logic [31:0] memAddr;
    logic        fRvalid;
    logic [31:0] fRdata;
    logic        dRvalid;
    logic [31:0] dRdata;
    logic        busy;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        fReq;
  logic [31:0] fAddr;
  logic        fReady;
  logic        fRvalid;
  logic [31:0] fRdata;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [1:0]  dSize;
  logic        dReady;
  logic        dRvalid;
  logic [31:0] dRdata;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [1:0]  memSize;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        busy;
  logic        err;

  int passCount;
  int checkCount;

  mem_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .f_req_i     (fReq),
    .f_addr_i    (fAddr),
    .f_ready_o   (fReady),
    .f_rvalid_o  (fRvalid),
    .f_rdata_o   (fRdata),
    .d_req_i     (dReq),
    .d_we_i      (dWe),
    .d_addr_i    (dAddr),
    .d_wdata_i   (dWdata),
    .d_size_i    (dSize),
    .d_ready_o   (dReady),
    .d_rvalid_o  (dRvalid),
    .d_rdata_o   (dRdata),
    .mem_req_o   (memReq),
    .mem_we_o    (memWe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_size_o  (memSize),
    .mem_gnt_i   (memGnt),
    .mem_rvalid_i(memRvalid),
    .mem_rdata_i (memRdata),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkStim(input logic fr, input logic [31:0] fa, input logic dr,
                                   input logic dw, input logic [31:0] da,
                                   input logic [31:0] dwd, input logic [1:0] ds,
                                   input logic g, input logic r, input logic [31:0] rd);
    stim_t s;
    s.rst = 1'b0; s.fReq = fr; s.fAddr = fa; s.dReq = dr; s.dWe = dw; s.dAddr = da;
    s.dWdata = dwd; s.dSize = ds; s.gnt = g; s.rv = r; s.rdata = rd;
    return s;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input logic fr, input logic dr,
                                 input logic mr, input logic [31:0] ma, input logic fv,
                                 input logic [31:0] fd, input logic dv,
                                 input logic [31:0] dd, input logic b);
    vec_t v;
    v.s = s; v.fReady = fr; v.dReady = dr; v.memReq = mr; v.memAddr = ma;
    v.fRvalid = fv; v.fRdata = fd; v.dRvalid = dv; v.dRdata = dd; v.busy = b;
    return v;
  endfunction

  // Drive one cycle's inputs just after the rising edge, then wait for the falling
  // edge so that the caller samples outputs mid-cycle.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    reset     = s.rst;
    fReq      = s.fReq;
    fAddr     = s.fAddr;
    dReq      = s.dReq;
    dWe       = s.dWe;
    dAddr     = s.dAddr;
    dWdata    = s.dWdata;
    dSize     = s.dSize;
    memGnt    = s.gnt;
    memRvalid = s.rv;
    memRdata  = s.rdata;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  vec_t  vecs[19];
  stim_t idle;
  stim_t s;

  initial begin
    passCount  = 0;
    checkCount = 0;
    idle = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = mkVec(mkStim(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0),              1, 0, 0, 32'h0,   0, 32'h0,        0, 0,     0);
    vecs[1]  = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),                     0, 0, 1, 32'h100, 0, 32'h0,        0, 0,     1);
    vecs[2]  = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF),          0, 0, 0, 32'h100, 0, 32'h0,        0, 0,     1);
    vecs[3]  = mkVec(idle,                                                     0, 0, 0, 32'h100, 1, 32'hDEADBEEF, 0, 0,     0);
    vecs[4]  = mkVec(idle,                                                     0, 0, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0,     0);
    vecs[5]  = mkVec(mkStim(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0),              1, 0, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0,     0);
    vecs[6]  = mkVec(mkStim(1, 32'h204, 0, 0, 0, 0, 0, 1, 0, 0),              0, 0, 1, 32'h200, 0, 32'hDEADBEEF, 0, 0,     1);
    vecs[7]  = mkVec(mkStim(1, 32'h204, 0, 0, 0, 0, 0, 0, 1, 32'h11111111),   0, 0, 0, 32'h200, 0, 32'hDEADBEEF, 0, 0,     1);
    vecs[8]  = mkVec(mkStim(1, 32'h204, 0, 0, 0, 0, 0, 0, 0, 0),              1, 0, 0, 32'h200, 1, 32'h11111111, 0, 0,     0);
    vecs[9]  = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),                     0, 0, 1, 32'h204, 0, 32'h11111111, 0, 0,     1);
    vecs[10] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222),          0, 0, 0, 32'h204, 0, 32'h11111111, 0, 0,     1);
    vecs[11] = mkVec(idle,                                                     0, 0, 0, 32'h204, 1, 32'h22222222, 0, 0,     0);
    vecs[12] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD),              0, 0, 0, 32'h204, 0, 32'h22222222, 0, 0,     0);
    vecs[13] = mkVec(idle,                                                     0, 0, 0, 32'h204, 0, 32'h22222222, 0, 0,     0);
    vecs[14] = mkVec(mkStim(0, 0, 1, 0, 32'h300, 0, 2, 0, 0, 0),              0, 1, 0, 32'h204, 0, 32'h22222222, 0, 0,     0);
    vecs[15] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD),              0, 0, 1, 32'h300, 0, 32'h22222222, 0, 0,     1);
    vecs[16] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),                     0, 0, 1, 32'h300, 0, 32'h22222222, 0, 0,     1);
    vecs[17] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33),                0, 0, 0, 32'h300, 0, 32'h22222222, 0, 0,     1);
    vecs[18] = mkVec(idle,                                                     0, 0, 0, 32'h300, 0, 32'h22222222, 1, 32'h33, 0);

    // Reset state
    s = idle;
    s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("rst.memReq",  {31'd0, memReq}, 32'd0);
    checkOutput("rst.memWe",   {31'd0, memWe}, 32'd0);
    checkOutput("rst.memAddr", memAddr, 32'd0);
    checkOutput("rst.memSize", {30'd0, memSize}, 32'd0);
    checkOutput("rst.fRvalid", {31'd0, fRvalid}, 32'd0);
    checkOutput("rst.dRvalid", {31'd0, dRvalid}, 32'd0);
    checkOutput("rst.fRdata",  fRdata, 32'd0);
    checkOutput("rst.dRdata",  dRdata, 32'd0);
    checkOutput("rst.busy",    {31'd0, busy}, 32'd0);
    checkOutput("rst.err",     {31'd0, err}, 32'd0);

    // Single fetch, back-to-back fetches, stray responses, data load
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("row%0d.fReady", i),  {31'd0, fReady},  {31'd0, vecs[i].fReady});
      checkOutput($sformatf("row%0d.dReady", i),  {31'd0, dReady},  {31'd0, vecs[i].dReady});
      checkOutput($sformatf("row%0d.memReq", i),  {31'd0, memReq},  {31'd0, vecs[i].memReq});
      checkOutput($sformatf("row%0d.memAddr", i), memAddr,          vecs[i].memAddr);
      checkOutput($sformatf("row%0d.fRvalid", i), {31'd0, fRvalid}, {31'd0, vecs[i].fRvalid});
      checkOutput($sformatf("row%0d.fRdata", i),  fRdata,           vecs[i].fRdata);
      checkOutput($sformatf("row%0d.dRvalid", i), {31'd0, dRvalid}, {31'd0, vecs[i].dRvalid});
      checkOutput($sformatf("row%0d.dRdata", i),  dRdata,           vecs[i].dRdata);
      checkOutput($sformatf("row%0d.busy", i),    {31'd0, busy},    {31'd0, vecs[i].busy});
    end

    // Store with the grant withheld for three cycles
    applyStimulus(mkStim(0, 0, 1, 1, 32'h2000, 32'h55, 0, 0, 0, 0));
    checkOutput("st.dReady", {31'd0, dReady}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, (i == 3), 0, 0));
      checkOutput($sformatf("st%0d.memReq", i),   {31'd0, memReq}, 32'd1);
      checkOutput($sformatf("st%0d.memWe", i),    {31'd0, memWe}, 32'd1);
      checkOutput($sformatf("st%0d.memSize", i),  {30'd0, memSize}, 32'd0);
      checkOutput($sformatf("st%0d.memAddr", i),  memAddr, 32'h2000);
      checkOutput($sformatf("st%0d.memWdata", i), memWdata, 32'h55);
    end
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hACC));
    checkOutput("st.memReqDrop", {31'd0, memReq}, 32'd0);
    checkOutput("st.dRvalidEarly", {31'd0, dRvalid}, 32'd0);
    applyStimulus(idle);
    checkOutput("st.dRvalid", {31'd0, dRvalid}, 32'd1);
    checkOutput("st.dRdata", dRdata, 32'hACC);
    checkOutput("st.fRvalid", {31'd0, fRvalid}, 32'd0);

    // Both requesters held high: four data grants then one fetch, repeating
    begin
      int grants;
      int budget;
      grants = 0;
      budget = 0;
      while (grants < 10 && budget < 60) begin
        applyStimulus(mkStim(1, 32'h600, 1, 0, 32'h700, 0, 2, 1, 1, 32'h99));
        budget++;
        if (fReady || dReady) begin
          checkOutput($sformatf("streak%0d.dReady", grants), {31'd0, dReady},
                      {31'd0, ((grants % 5) != 4)});
          checkOutput($sformatf("streak%0d.fReady", grants), {31'd0, fReady},
                      {31'd0, ((grants % 5) == 4)});
          grants++;
        end
      end
      checkOutput("streak.budget", grants, 10);
      for (int i = 0; i < 4; i++) begin
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h99));
      end
      checkOutput("streak.drain", {31'd0, busy}, 32'd0);
    end

    // Load that never gets a response times out after 64 WAIT cycles
    applyStimulus(mkStim(0, 0, 1, 0, 32'h400, 0, 2, 0, 0, 0));
    checkOutput("to.dReady", {31'd0, dReady}, 32'd1);
    checkOutput("to.errBefore", {31'd0, err}, 32'd0);
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    begin
      int early;
      early = 0;
      for (int i = 0; i < 64; i++) begin
        applyStimulus(idle);
        if (dRvalid || !busy) early++;
      end
      checkOutput("to.noEarlyPulse", early, 0);
    end
    applyStimulus(idle);
    checkOutput("to.dRvalid", {31'd0, dRvalid}, 32'd1);
    checkOutput("to.dRdata", dRdata, 32'd0);
    checkOutput("to.err", {31'd0, err}, 32'd1);
    checkOutput("to.busy", {31'd0, busy}, 32'd0);
    applyStimulus(mkStim(1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("to.pulseOnce", {31'd0, dRvalid}, 32'd0);
    checkOutput("to.errSticky", {31'd0, err}, 32'd1);
    checkOutput("to.nextReady", {31'd0, fReady}, 32'd1);
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A));
    applyStimulus(idle);
    checkOutput("to.nextRvalid", {31'd0, fRvalid}, 32'd1);
    checkOutput("to.nextRdata", fRdata, 32'h5A5A);
    checkOutput("to.errStill", {31'd0, err}, 32'd1);

    // Reset in WAIT, then a late response after release
    applyStimulus(mkStim(0, 0, 1, 0, 32'h800, 0, 2, 0, 0, 0));
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    s = idle;
    s.rst = 1'b1;
    applyStimulus(s);
    checkOutput("rw.busyInWait", {31'd0, busy}, 32'd1);
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77));
    checkOutput("rw.busy", {31'd0, busy}, 32'd0);
    checkOutput("rw.err", {31'd0, err}, 32'd0);
    checkOutput("rw.dRvalid", {31'd0, dRvalid}, 32'd0);
    checkOutput("rw.memReq", {31'd0, memReq}, 32'd0);
    checkOutput("rw.dRdata", dRdata, 32'd0);
    applyStimulus(idle);
    checkOutput("rw.lateDRvalid", {31'd0, dRvalid}, 32'd0);
    checkOutput("rw.lateFRvalid", {31'd0, fRvalid}, 32'd0);
    checkOutput("rw.lateBusy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
